// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall sequencer: stall bus values, divider FSM states
// and the default divider timeout.
package pipe_stall_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;

    // Stall bus bit order is {WB, MEM, EX, ID, IF, PC}
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;

    localparam int DIV_TIMEOUT_DEF = 64;
    localparam int WAIT_CNT_W      = 7;

    typedef enum logic [1:0] {
        DIVC_IDLE  = 2'd0,
        DIVC_START = 2'd1,
        DIVC_WAIT  = 2'd2,
        DIVC_DONE  = 2'd3
    } divc_state_e;

    // A legal stall bus is a run of ones starting at PC: bit k set implies bits 0..k-1 set
    function automatic logic stall_is_monotone(input stall_bus_t s);
        return (s & (s + 6'd1)) == 6'd0;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake and status bundle between the stall sequencer and the ID/EX stages.
// master = stall sequencer side, slave = pipeline/divider side.
interface pipe_stall_ctrl_if;
    import pipe_stall_ctrl_pkg::*;

    logic        id_stallreq;
    logic        ex_div_req;
    logic        div_ready;
    logic        div_start;
    logic        ex_div_done;
    logic        div_timeout;
    stall_bus_t  stall;
    logic [31:0] lu_stall_cnt;
    logic [31:0] div_stall_cnt;

    modport master (
        input  id_stallreq,
        input  ex_div_req,
        input  div_ready,
        output div_start,
        output ex_div_done,
        output div_timeout,
        output stall,
        output lu_stall_cnt,
        output div_stall_cnt
    );

    modport slave (
        output id_stallreq,
        output ex_div_req,
        output div_ready,
        input  div_start,
        input  ex_div_done,
        input  div_timeout,
        input  stall,
        input  lu_stall_cnt,
        input  div_stall_cnt
    );

endinterface

// File: rtl/pipe_stall_ctrl_stall_perf_cnt.sv
// Load-use and divider stall-cycle performance counters, 32-bit wrapping.
// Only compiled when STALL_PERF_EN is defined.
`ifdef STALL_PERF_EN
module stall_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        lu_inc,
    input  logic        div_inc,
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] div_stall_cnt
);

    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic [31:0] div_cnt_q, div_cnt_d;

    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        div_cnt_d = div_cnt_q;
        if (lu_inc) begin
            lu_cnt_d = lu_cnt_q + 32'd1;
        end
        if (div_inc) begin
            div_cnt_d = div_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lu_cnt_q  <= 32'd0;
            div_cnt_q <= 32'd0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign lu_stall_cnt  = lu_cnt_q;
    assign div_stall_cnt = div_cnt_q;

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer: merges ID load-use requests and sequences the multi-cycle divider.
// Optional perf counters are enabled with the STALL_PERF_EN macro.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.master  bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE  = WAIT_CNT_W'(1);

    divc_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   div_timeout_q, div_timeout_d;
    logic                   div_start_q, div_start_d;
    logic                   ex_div_done_q, ex_div_done_d;
    logic                   stall_ex_q, stall_ex_d;
    stall_bus_t             stall_mux;

    // Outputs are decoded from the next state so they come straight out of flops
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        div_timeout_d = div_timeout_q;
        case (state_q)
            DIVC_IDLE: begin
                if (bus.ex_div_req) begin
                    state_d = DIVC_START;
                end
            end
            DIVC_START: begin
                state_d    = DIVC_WAIT;
                wait_cnt_d = '0;
            end
            DIVC_WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_ONE;
                if (bus.div_ready) begin
                    state_d = DIVC_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    div_timeout_d = 1'b1;
                    state_d       = DIVC_DONE;
                end
            end
            DIVC_DONE: begin
                state_d = DIVC_IDLE;
            end
            default: begin
                state_d = DIVC_IDLE;
            end
        endcase
        div_start_d   = (state_d == DIVC_START);
        ex_div_done_d = (state_d == DIVC_DONE);
        stall_ex_d    = (state_d == DIVC_START) || (state_d == DIVC_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= DIVC_IDLE;
            wait_cnt_q    <= '0;
            div_timeout_q <= 1'b0;
            div_start_q   <= 1'b0;
            ex_div_done_q <= 1'b0;
            stall_ex_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            div_timeout_q <= div_timeout_d;
            div_start_q   <= div_start_d;
            ex_div_done_q <= ex_div_done_d;
            stall_ex_q    <= stall_ex_d;
        end
    end

    // Load-use stall is combinational from ID and honoured only while no divide is in flight
    always_comb begin
        stall_mux = STALL_NONE;
        if (stall_ex_q) begin
            stall_mux = STALL_EX;
        end else if ((state_q == DIVC_IDLE) && bus.id_stallreq) begin
            stall_mux = STALL_ID;
        end
    end

    assign bus.stall       = stall_mux;
    assign bus.div_start   = div_start_q;
    assign bus.ex_div_done = ex_div_done_q;
    assign bus.div_timeout = div_timeout_q;

`ifdef STALL_PERF_EN
    stall_perf_cnt u_perf (
        .clk           (clk),
        .rst           (rst),
        .lu_inc        (stall_mux == STALL_ID),
        .div_inc       (stall_mux == STALL_EX),
        .lu_stall_cnt  (bus.lu_stall_cnt),
        .div_stall_cnt (bus.div_stall_cnt)
    );
`else
    assign bus.lu_stall_cnt  = 32'd0;
    assign bus.div_stall_cnt = 32'd0;
`endif

    a_stall_monotone: assert property (@(posedge clk) disable iff (!rst)
        stall_is_monotone(bus.stall));

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard testbench for pipe_stall_ctrl: transaction-level stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT = 64;
    localparam logic [5:0] EXP_NONE = 6'b000000;
    localparam logic [5:0] EXP_ID   = 6'b000111;
    localparam logic [5:0] EXP_EX   = 6'b001111;

    typedef struct {
        logic        chk_stall;
        logic [5:0]  stall;
        logic        start;
        logic        done;
        logic        tmo;
        logic [31:0] lu;
        logic [31:0] dv;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(.DIV_TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned model_lu = 0;
    int unsigned model_dv = 0;
    logic        model_tmo = 1'b0;

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic compareField(input string name, input string tag,
                                input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s (%s) t=%0t actual=%0h required=%0h", name, tag, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.chk_stall) begin
            compareField("stall", e.tag, 32'(bus.stall), 32'(e.stall));
        end
        compareField("div_start", e.tag, 32'(bus.div_start), 32'(e.start));
        compareField("ex_div_done", e.tag, 32'(bus.ex_div_done), 32'(e.done));
        compareField("div_timeout", e.tag, 32'(bus.div_timeout), 32'(e.tmo));
        compareField("lu_stall_cnt", e.tag, bus.lu_stall_cnt, e.lu);
        compareField("div_stall_cnt", e.tag, bus.div_stall_cnt, e.dv);
    endtask

    // One clock cycle: drive inputs, record what the outputs must be during this cycle
    task automatic applyStimulus(input logic rst_v, input logic id, input logic ex,
                                 input logic rdy, input logic [5:0] stall_e,
                                 input logic start_e, input logic done_e,
                                 input logic chk_stall, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = rst_v;
        bus.id_stallreq = id;
        bus.ex_div_req  = ex;
        bus.div_ready   = rdy;
        e.chk_stall = chk_stall;
        e.stall     = stall_e;
        e.start     = start_e;
        e.done      = done_e;
        e.tmo       = model_tmo;
        e.lu        = model_lu;
        e.dv        = model_dv;
        e.tag       = tag;
        sb.push_back(e);
`ifdef STALL_PERF_EN
        if (stall_e == EXP_ID) model_lu++;
        if (stall_e == EXP_EX) model_dv++;
`endif
        if (!rst_v) begin
            model_lu  = 0;
            model_dv  = 0;
            model_tmo = 1'b0;
        end
    endtask

    task automatic idleCycle(input logic id, input string tag);
        applyStimulus(1'b1, id, 1'b0, rbit(), id ? EXP_ID : EXP_NONE, 1'b0, 1'b0, 1'b1, tag);
    endtask

    // A divide whose result arrives on WAIT cycle lat; abort_at>0 resets on that WAIT cycle
    task automatic doDivide(input int lat, input int abort_at, input logic id_first,
                            input string tag);
        int n;
        applyStimulus(1'b1, id_first, 1'b1, rbit(), id_first ? EXP_ID : EXP_NONE,
                      1'b0, 1'b0, 1'b1, {tag, "_req"});
        applyStimulus(1'b1, rbit(), rbit(), rbit(), EXP_EX, 1'b1, 1'b0, 1'b1, {tag, "_start"});
        n = (lat > TIMEOUT) ? TIMEOUT : lat;
        for (int k = 1; k <= n; k++) begin
            if (k == abort_at) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, EXP_EX, 1'b0, 1'b0, 1'b1, {tag, "_abort"});
                return;
            end
            applyStimulus(1'b1, rbit(), rbit(), (k == lat), EXP_EX, 1'b0, 1'b0, 1'b1,
                          {tag, "_wait"});
        end
        if (lat > TIMEOUT) model_tmo = 1'b1;
        applyStimulus(1'b1, rbit(), rbit(), rbit(), EXP_NONE, 1'b0, 1'b1, 1'b1, {tag, "_done"});
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput(mon_e);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r;
        rst             = 1'b0;
        bus.id_stallreq = 1'b1;
        bus.ex_div_req  = 1'b1;
        bus.div_ready   = 1'b1;

        // Reset held with every input high; stall is Mealy on ID so it is not checked here
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, EXP_NONE, 1'b0, 1'b0, 1'b0, "reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, EXP_NONE, 1'b0, 1'b0, 1'b1, "post_reset");

        idleCycle(1'b1, "lu_1");
        idleCycle(1'b1, "lu_2");
        idleCycle(1'b0, "lu_end");
        idleCycle(1'b0, "lu_cnt");

        doDivide(33, 0, 1'b0, "div33");
        idleCycle(1'b0, "gap");
        doDivide(20, 0, 1'b1, "simul");
        idleCycle(1'b1, "lu_after_div");
        doDivide(1, 0, 1'b0, "div1");
        doDivide(TIMEOUT, 0, 1'b0, "div_edge");
        doDivide(5, 0, 1'b0, "b2b_a");
        doDivide(7, 0, 1'b1, "b2b_b");

        doDivide(1000, 0, 1'b0, "timeout");
        repeat (3) idleCycle(rbit(), "tmo_sticky");
        doDivide(10, 0, 1'b0, "after_tmo");

        doDivide(1000, 5, 1'b0, "abort");
        idleCycle(1'b0, "abort_idle");
        doDivide(12, 0, 1'b0, "fresh");

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(9, 0);
            if (r <= 5) begin
                idleCycle(rbit(), "rnd_idle");
            end else if (r <= 8) begin
                doDivide($urandom_range(70, 1), 0, rbit(), "rnd_div");
            end else begin
                doDivide(70, $urandom_range(10, 1), rbit(), "rnd_abort");
                idleCycle(1'b0, "rnd_abort_idle");
            end
        end
        idleCycle(1'b0, "tail");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
